fetch_frontend: RTL and testbench
=================================

FETCH_FRONTEND -- requirements
Module: fetch_frontend

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, PC and address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, maximum in-flight plus buffered fetches; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have clk  input  1  sole clock, rising edge.
REQ-007 SHALL have async_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have redirect_valid  input  1  taken branch/jump from execute; single-cycle pulse.
REQ-009 SHALL have redirect_pc  input  PC_WIDTH  target PC, sampled when redirect_valid=1.
REQ-010 SHALL have PC_F  output  PC_WIDTH  IMEM request address.
REQ-011 SHALL have pc_valid_out  output  1  IMEM request valid.
REQ-012 SHALL have pc_ready_in  input  1  IMEM accepts request.
REQ-013 SHALL have instruction  input  DATA_WIDTH  IMEM response data.
REQ-014 SHALL have instruction_valid_in  input  1  IMEM response valid; responses in request order.
REQ-015 SHALL have instruction_ready_out  output  1  response accept; constant 1 after reset.
REQ-016 SHALL have instr_D  output  DATA_WIDTH  instruction to decode.
REQ-017 SHALL have PC_D and PC_plus_4_D  outputs  PC_WIDTH each  PC of instr_D and PC+4.
REQ-018 SHALL have valid_out  output  1  and ready_in  input  1  decode-side handshake.

Function
REQ-019 SHALL hold DEPTH-entry ring; each entry = {pc, instruction, filled}; pointers alloc, fill, read (log2 DEPTH bits, natural wrap).
REQ-020 SHALL assert pc_valid_out when run=1, redirect_valid=0 and occupancy (alloc-read, registered) < DEPTH.
REQ-021 SHALL on issue (pc_valid_out & pc_ready_in) write PC_F into entry[alloc], clear filled, increment alloc, PC_F <= PC_F+4 (mod 2^PC_WIDTH).
REQ-022 SHALL hold PC_F and pc_valid_out stable while pc_valid_out=1 and pc_ready_in=0.
REQ-023 SHALL on accepted response with drop_cnt=0 write instruction into entry[fill], set filled, increment fill.
REQ-024 SHALL drive valid_out = entry[read].filled & occupancy>0; instr_D/PC_D from entry[read]; PC_plus_4_D = PC_D+4.
REQ-025 SHALL pop (read++) on valid_out & ready_in; hold outputs stable otherwise.
REQ-026 SHALL give response-to-valid_out latency 1 cycle when buffer empty; issue-to-response latency is IMEM-defined.
REQ-027 SHALL on redirect_valid: PC_F <= redirect_pc, alloc/fill/read <= 0, all filled cleared, valid_out=0 next cycle, drop_cnt <= in-flight (alloc-fill) minus 1 if a response arrives that cycle.
REQ-028 SHALL discard responses while drop_cnt>0, decrementing drop_cnt per response.
REQ-029 SHALL suppress issue and pop in the redirect cycle; redirect wins over every simultaneous event.
REQ-030 SHALL allow issue, response and pop in the same cycle with counts updated consistently.
REQ-031 SHALL never overflow: occupancy at DEPTH blocks issue; ring full blocks no response (space reserved at issue).

Reset
REQ-032 SHALL on async_rst_n=0 set PC_F=RESET_PC, pointers=0, drop_cnt=0, filled=0, run=0; outputs pc_valid_out=0, valid_out=0, instruction_ready_out=0, instr_D/PC_D/PC_plus_4_D=0 (PC_plus_4_D forced to 0 while empty).
REQ-033 SHALL set run=1 on first rising edge after release; first request RESET_PC on the following cycle.
REQ-034 SHALL abandon all in-flight state on reset mid-operation; IMEM is reset on the same signal.

Structure
REQ-035 SHALL place fetch_entry_t {pc, instruction} in rv32i_types_pkg.
REQ-036 SHALL be a single module; no sub-module required.

Verification
REQ-037 SHALL cover: release reset, IMEM always ready, 1-cycle response -> PC_F 0x0,0x4,0x8..., decode sees same PC order with PC_plus_4_D = PC_D+4.
REQ-038 SHALL cover: DEPTH=4, ready_in=0 -> exactly 4 issues, then pc_valid_out=0 until one pop.
REQ-039 SHALL cover: redirect to 0x100 with 3 in flight -> 3 responses dropped, next valid_out has PC_D=0x100.
REQ-040 SHALL cover: redirect coinciding with response and pop -> response dropped, drop_cnt = in-flight-1, no pop.
REQ-041 SHALL cover: pc_ready_in held 0 for 5 cycles -> PC_F stable, no issue counted.
REQ-042 SHALL cover: async_rst_n low mid-stream -> all outputs at reset values immediately, restart from RESET_PC.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I front-end types: one fetch-buffer entry holds a PC and its
// instruction word. The entry widths bound the PC/instruction widths the
// fetch front end can carry.
package rv32i_types_pkg;

    localparam int unsigned FETCH_PC_W   = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_DATA_W-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_frontend.sv
// Instruction fetch front end: issues sequential PCs to IMEM, buffers the
// in-order responses in a DEPTH-entry ring and hands them to decode with a
// valid/ready handshake. A redirect flushes the ring and discards the
// responses still owed by IMEM for the abandoned path.
module fetch_frontend
    import rv32i_types_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [PC_WIDTH-1:0]   PC_F,
    output logic                  pc_valid_out,
    input  logic                  pc_ready_in,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  instruction_valid_in,
    output logic                  instruction_ready_out,
    output logic [DATA_WIDTH-1:0] instr_D,
    output logic [PC_WIDTH-1:0]   PC_D,
    output logic [PC_WIDTH-1:0]   PC_plus_4_D,
    output logic                  valid_out,
    input  logic                  ready_in
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    // Repeated redirects can stack owed responses beyond one ring's worth.
    localparam int unsigned DW = AW + 3;
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

    fetch_entry_t          r_ring [DEPTH];
    logic [DEPTH-1:0]      r_filled;
    logic [AW-1:0]         r_alloc, r_fill, r_read;
    logic [OW-1:0]         r_occ;       // allocated, not yet popped
    logic [OW-1:0]         r_inflight;  // allocated, response not yet received
    logic [DW-1:0]         r_drop;      // responses still owed to a flushed path
    logic                  r_run;
    logic [PC_WIDTH-1:0]   r_pc;

    logic                  w_redirect;
    logic                  w_resp;
    logic                  w_fill;
    logic                  w_drop;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_valid;
    fetch_entry_t          w_head;
    logic [PC_WIDTH-1:0]   w_pc_d;

    assign w_redirect = redirect_valid & r_run;
    assign w_resp     = instruction_valid_in & r_run;
    assign w_fill     = w_resp & ~w_redirect & (r_drop == '0);
    assign w_drop     = w_resp & ~w_redirect & (r_drop != '0);

    assign pc_valid_out = r_run & ~redirect_valid & (r_occ != OCC_FULL);
    assign w_issue      = pc_valid_out & pc_ready_in;

    assign w_head  = r_ring[r_read];
    assign w_valid = r_filled[r_read] & (r_occ != '0);
    assign w_pop   = w_valid & ready_in & ~w_redirect;
    assign w_pc_d  = PC_WIDTH'(w_head.pc);

    assign PC_F                  = r_pc;
    assign instruction_ready_out = r_run;
    assign valid_out             = w_valid;
    // Decode-side data reads as zero whenever nothing valid is presented.
    assign instr_D     = w_valid ? DATA_WIDTH'(w_head.instruction) : '0;
    assign PC_D        = w_valid ? w_pc_d : '0;
    assign PC_plus_4_D = w_valid ? w_pc_d + PC_WIDTH'(4) : '0;

    // Control state: run flag, fetch PC, ring pointers and occupancy counters.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_run      <= 1'b0;
            r_pc       <= RESET_PC;
            r_alloc    <= '0;
            r_fill     <= '0;
            r_read     <= '0;
            r_occ      <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_redirect) begin
                // Everything requested but not yet answered becomes owed
                // garbage; a response landing this cycle pays one off now.
                r_pc       <= redirect_pc;
                r_alloc    <= '0;
                r_fill     <= '0;
                r_read     <= '0;
                r_occ      <= '0;
                r_inflight <= '0;
                r_drop     <= r_drop + DW'(r_inflight) - DW'(w_resp);
            end else begin
                if (w_issue) begin
                    r_alloc <= r_alloc + AW'(1);
                    r_pc    <= r_pc + PC_WIDTH'(4);
                end
                if (w_fill) r_fill <= r_fill + AW'(1);
                if (w_pop)  r_read <= r_read + AW'(1);
                if (w_drop) r_drop <= r_drop - DW'(1);
                r_occ      <= r_occ + OW'(w_issue) - OW'(w_pop);
                r_inflight <= r_inflight + OW'(w_issue) - OW'(w_fill);
            end
        end
    end

    // Per-entry filled flags: cleared on allocation, set when the response lands.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_filled <= '0;
        end else if (w_redirect) begin
            r_filled <= '0;
        end else begin
            if (w_issue) r_filled[r_alloc] <= 1'b0;
            if (w_fill)  r_filled[r_fill]  <= 1'b1;
        end
    end

    // Ring payload; contents are only observed behind a filled flag, so no reset.
    always_ff @(posedge clk) begin
        if (w_issue) r_ring[r_alloc].pc         <= FETCH_PC_W'(r_pc);
        if (w_fill)  r_ring[r_fill].instruction <= FETCH_DATA_W'(instruction);
    end

endmodule

// File: tb/tb_fetch_frontend.sv
// Scoreboard bench for fetch_frontend: stimulus pushes hand-computed issue
// PCs and decode PCs into queues; a negedge monitor pops and compares every
// IMEM issue and every decode pop. A small in-order IMEM model answers
// requests one cycle after issue unless held.
module tb_fetch_frontend;

    logic        clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] PC_F;
    logic        pc_valid_out;
    logic        pc_ready_in = 1'b0;
    logic [31:0] instruction = '0;
    logic        instruction_valid_in = 1'b0;
    logic        instruction_ready_out;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC_plus_4_D;
    logic        valid_out;
    logic        ready_in = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          issue_cnt = 0;
    int          base = 0;
    bit          imem_hold = 1'b0;
    logic [31:0] exp_iss [$];
    logic [31:0] exp_dec [$];
    logic [31:0] pend [$];
    logic [31:0] e;

    always #5 clk = ~clk;

    fetch_frontend #(
        .PC_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .PC_F(PC_F), .pc_valid_out(pc_valid_out), .pc_ready_in(pc_ready_in),
        .instruction(instruction), .instruction_valid_in(instruction_valid_in),
        .instruction_ready_out(instruction_ready_out),
        .instr_D(instr_D), .PC_D(PC_D), .PC_plus_4_D(PC_plus_4_D),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push2(input logic [31:0] pc, input bit dec);
        exp_iss.push_back(pc);
        if (dec) exp_dec.push_back(pc);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_iss.size() != 0 || exp_dec.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        n_chk++;
        if (exp_iss.size() == 0 && exp_dec.size() == 0) n_pass++;
        else $display("FAIL %s: %0d issues and %0d pops still pending, want 0 and 0",
                      name, exp_iss.size(), exp_dec.size());
    endtask

    // IMEM model: in-order, one-cycle response, reset with the DUT.
    always @(posedge clk) begin
        if (!async_rst_n) begin
            pend.delete();
        end else begin
            if (instruction_valid_in && instruction_ready_out) void'(pend.pop_front());
            if (pc_valid_out && pc_ready_in) pend.push_back(PC_F);
        end
        #2;
        if (async_rst_n && !imem_hold && pend.size() > 0) begin
            instruction_valid_in = 1'b1;
            instruction          = instr_of(pend[0]);
        end else begin
            instruction_valid_in = 1'b0;
            instruction          = '0;
        end
    end

    // Monitor: compares each issue and each decode pop against the scoreboard.
    always @(negedge clk) begin
        if (async_rst_n) begin
            if (pc_valid_out && pc_ready_in) begin
                issue_cnt++;
                if (exp_iss.size() == 0) begin
                    n_chk++;
                    $display("FAIL issue_unexpected: PC_F=%h issued, none expected", PC_F);
                end else begin
                    check("issue_pc", PC_F, exp_iss.pop_front());
                end
            end
            if (valid_out && ready_in && !redirect_valid) begin
                if (exp_dec.size() == 0) begin
                    n_chk++;
                    $display("FAIL dec_unexpected: PC_D=%h popped, none expected", PC_D);
                end else begin
                    e = exp_dec.pop_front();
                    check("dec_pc", PC_D, e);
                    check("dec_instr", instr_D, instr_of(e));
                    check("dec_pc4", PC_plus_4_D, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_pc_valid", 32'(pc_valid_out), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_ird", 32'(instruction_ready_out), 32'd0);
        check("rst_PC_F", PC_F, 32'h0);
        check("rst_instr_D", instr_D, 32'h0);
        check("rst_PC_D", PC_D, 32'h0);
        check("rst_PC4", PC_plus_4_D, 32'h0);

        @(negedge clk); async_rst_n = 1'b1;
        @(posedge clk); #1;
        check("run_pc_valid", 32'(pc_valid_out), 32'd1);
        check("run_PC_F", PC_F, 32'h0);
        check("run_ird", 32'(instruction_ready_out), 32'd1);

        // Streaming, IMEM always ready, decode always ready
        base = issue_cnt;
        for (int i = 0; i < 8; i++) push2(32'(i * 4), 1'b1);
        pc_ready_in = 1'b1; ready_in = 1'b1;
        repeat (8) @(posedge clk); #1; pc_ready_in = 1'b0;
        drain("drain_seq");
        check("seq_issue_cnt", 32'(issue_cnt - base), 32'd8);

        // Decode stalled: exactly DEPTH issues, then stall until one pop
        base = issue_cnt;
        ready_in = 1'b0; pc_ready_in = 1'b1;
        push2(32'h20, 1'b0); push2(32'h24, 1'b0); push2(32'h28, 1'b0); push2(32'h2C, 1'b0);
        repeat (8) @(posedge clk); #1;
        check("full_pc_valid", 32'(pc_valid_out), 32'd0);
        check("full_issue_cnt", 32'(issue_cnt - base), 32'd4);
        check("full_head_valid", 32'(valid_out), 32'd1);
        check("full_head_pc", PC_D, 32'h20);
        exp_dec.push_back(32'h20); exp_iss.push_back(32'h30);
        ready_in = 1'b1;
        @(posedge clk); #1; ready_in = 1'b0;
        check("reopen_pc_valid", 32'(pc_valid_out), 32'd1);
        @(posedge clk); #1; pc_ready_in = 1'b0;
        exp_dec.push_back(32'h24); exp_dec.push_back(32'h28);
        exp_dec.push_back(32'h2C); exp_dec.push_back(32'h30);
        ready_in = 1'b1;
        drain("drain_full");

        // IMEM back-pressure: PC_F held, no issue
        base = issue_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_PC_F", PC_F, 32'h34);
            check("hold_pc_valid", 32'(pc_valid_out), 32'd1);
        end
        check("hold_issue_cnt", 32'(issue_cnt - base), 32'd0);

        // Redirect with 3 in flight: all 3 responses dropped
        imem_hold = 1'b1; pc_ready_in = 1'b1;
        push2(32'h34, 1'b0); push2(32'h38, 1'b0); push2(32'h3C, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("inflight_valid_out", 32'(valid_out), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        check("redir_blocks_issue", 32'(pc_valid_out), 32'd0);
        @(posedge clk); #1; redirect_valid = 1'b0; imem_hold = 1'b0;
        check("redir_PC_F", PC_F, 32'h100);
        check("redir_valid_out", 32'(valid_out), 32'd0);
        push2(32'h100, 1'b1); push2(32'h104, 1'b1);
        repeat (2) @(posedge clk); #1; pc_ready_in = 1'b0;
        drain("drain_redir");

        // Redirect coinciding with a response and a would-be pop
        ready_in = 1'b0; imem_hold = 1'b1; pc_ready_in = 1'b1;
        push2(32'h108, 1'b0); push2(32'h10C, 1'b0); push2(32'h110, 1'b0);
        repeat (3) @(posedge clk); #1; pc_ready_in = 1'b0; imem_hold = 1'b0;
        @(posedge clk); #1;
        check("coinc_head_valid", 32'(valid_out), 32'd1);
        check("coinc_head_pc", PC_D, 32'h108);
        redirect_valid = 1'b1; redirect_pc = 32'h200; ready_in = 1'b1; pc_ready_in = 1'b1;
        @(posedge clk); #1; redirect_valid = 1'b0;
        check("coinc_PC_F", PC_F, 32'h200);
        check("coinc_valid_out", 32'(valid_out), 32'd0);
        push2(32'h200, 1'b1); push2(32'h204, 1'b1);
        repeat (2) @(posedge clk); #1; pc_ready_in = 1'b0;
        drain("drain_coinc");

        // Asynchronous reset mid-stream, then restart from RESET_PC
        ready_in = 1'b0; pc_ready_in = 1'b1;
        push2(32'h208, 1'b0); push2(32'h20C, 1'b0); push2(32'h210, 1'b0);
        repeat (3) @(posedge clk); #1; pc_ready_in = 1'b0;
        check("mid_valid_out", 32'(valid_out), 32'd1);
        #2; async_rst_n = 1'b0; #1;
        check("arst_pc_valid", 32'(pc_valid_out), 32'd0);
        check("arst_valid_out", 32'(valid_out), 32'd0);
        check("arst_ird", 32'(instruction_ready_out), 32'd0);
        check("arst_PC_F", PC_F, 32'h0);
        check("arst_PC_D", PC_D, 32'h0);
        check("arst_instr_D", instr_D, 32'h0);
        check("arst_PC4", PC_plus_4_D, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); async_rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_PC_F", PC_F, 32'h0);
        check("restart_pc_valid", 32'(pc_valid_out), 32'd1);
        push2(32'h0, 1'b1); push2(32'h4, 1'b1);
        ready_in = 1'b1; pc_ready_in = 1'b1;
        repeat (2) @(posedge clk); #1; pc_ready_in = 1'b0;
        drain("drain_restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
